goldschmidt_iter_ctrl: RTL and testbench

//  Sequential Goldschmidt iteration engine for the fixed-point divider datapath.
//  - Accepts numerator N and normalised divisor D, then iterates ITERS times:
//    F = 2 - D; N <= N*F; D <= D*F.
//  - Produces quotient q ~= N/D. Sits directly upstream of the 16-bit result register bank.
//  - start/busy/done handshake to the top-level controller.

---
 rtl/gs_pkg.sv | 17 +
 rtl/gs_fxmul.sv | 33 +++
 rtl/goldschmidt_iter_ctrl.sv | 81 ++++++++
 tb/tb_goldschmidt_iter_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/gs_pkg.sv
// Shared defaults, fixed-point constants and FSM state encoding for the
// Goldschmidt divider iteration engine.
package gs_pkg;

    localparam int GS_WIDTH = 16;
    localparam int GS_FRAC  = 14;
    localparam int GS_ITERS = 4;

    localparam logic [GS_WIDTH-1:0] ONE  = GS_WIDTH'(1) << GS_FRAC;
    localparam logic [GS_WIDTH-1:0] TWO  = ONE << 1;
    localparam logic [GS_WIDTH-1:0] QMAX = '1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/gs_fxmul.sv
// Unsigned fixed-point multiply with saturation to all ones.
// GS_ROUND_EN selects round-half-up instead of truncation.
module gs_fxmul
    import gs_pkg::*;
#(
    parameter int WIDTH = GS_WIDTH,
    parameter int FRAC  = GS_FRAC
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

`ifdef GS_ROUND_EN
    localparam logic [2*WIDTH:0] RND = (2*WIDTH+1)'(1) << (FRAC-1);
`else
    localparam logic [2*WIDTH:0] RND = '0;
`endif

    logic [2*WIDTH:0] ax, bx, prod, shifted;
    logic             sat;

    // One spare top bit so the rounding carry is seen by the saturation test.
    always_comb begin
        ax      = {{(WIDTH+1){1'b0}}, a};
        bx      = {{(WIDTH+1){1'b0}}, b};
        prod    = ax * bx + RND;
        shifted = prod >> FRAC;
        sat     = |shifted[2*WIDTH:WIDTH];
        y       = sat ? '1 : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/goldschmidt_iter_ctrl.sv
// Sequential Goldschmidt iteration engine: q ~= n_in/d_in after ITERS passes
// of F = 2 - D; N *= F; D *= F. Optional rounding via GS_ROUND_EN.
module goldschmidt_iter_ctrl
    import gs_pkg::*;
#(
    parameter int WIDTH = GS_WIDTH,
    parameter int FRAC  = GS_FRAC,
    parameter int ITERS = GS_ITERS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] n_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] q
);

    localparam int               CW    = $clog2(ITERS+1);
    localparam int               NW    = WIDTH-FRAC+1;
    localparam logic [WIDTH-1:0] F_TWO = WIDTH'(2) << FRAC;

    logic [1:0]       state;
    logic [WIDTH-1:0] n_r, d_r, f, n_nx, d_nx;
    logic [CW-1:0]    cnt;
    logic             d_ok;

    // Normalised divisor in [0.5,1.0): integer bits zero, MSB fraction bit set.
    assign d_ok = (d_in[WIDTH-1:FRAC-1] == NW'(1));
    assign f    = F_TWO - d_r;

    gs_fxmul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_n (.a(n_r), .b(f), .y(n_nx));
    gs_fxmul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_d (.a(d_r), .b(f), .y(d_nx));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            n_r   <= '0;
            d_r   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            q     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (d_ok) begin
                        state <= ITER;
                        n_r   <= n_in;
                        d_r   <= d_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        err   <= 1'b0;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                        q     <= '1;
                    end
                end
                ITER: begin
                    n_r <= n_nx;
                    d_r <= d_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITERS-1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        q     <= n_nx;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_goldschmidt_iter_ctrl.sv
// Randomised self-checking bench for goldschmidt_iter_ctrl against an
// arithmetic reference of the Goldschmidt recurrence (GS_ROUND_EN aware).
module tb_goldschmidt_iter_ctrl;

    localparam int ITERS = 4;

`ifdef GS_ROUND_EN
    localparam longint RND = 64'd1 << 13;
`else
    localparam longint RND = 64'd0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] n_in = '0;
    logic [15:0] d_in = '0;
    logic        busy, done, err;
    logic [15:0] q;

    int n_tests = 0;
    int n_fail  = 0;

    goldschmidt_iter_ctrl #(.WIDTH(16), .FRAC(14), .ITERS(ITERS)) dut (
        .clk(clk), .reset(reset), .start(start), .n_in(n_in), .d_in(d_in),
        .busy(busy), .done(done), .err(err), .q(q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Q2.14 product with optional rounding, saturating above 4.0.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        longint p;
        p = longint'(a) * longint'(b) + RND;
        if (p >= (64'd1 << 30)) return 16'hFFFF;
        return 16'(p / 16384);
    endfunction

    task automatic ref_div(input logic [15:0] n, input logic [15:0] d,
                           output logic [15:0] eq, output logic ee, output int lat);
        logic [15:0] nn, dd, f;
        if (d < 16'h2000 || d >= 16'h4000) begin
            eq = 16'hFFFF; ee = 1'b1; lat = 1;
        end else begin
            nn = n; dd = d;
            for (int i = 0; i < ITERS; i++) begin
                f  = 16'(32'h8000 - 32'(dd));
                nn = ref_mul(nn, f);
                dd = ref_mul(dd, f);
            end
            eq = nn; ee = 1'b0; lat = ITERS + 1;
        end
    endtask

    function automatic logic near(input logic [15:0] a, input logic [15:0] b, input int tol);
        int diff;
        diff = int'(a) - int'(b);
        return (diff <= tol) && (diff >= -tol);
    endfunction

    // Pulse start for one cycle and wait (bounded) for done; returns result.
    task automatic run_op(input string tag, input logic [15:0] n, input logic [15:0] d,
                          output logic [15:0] qo);
        logic [15:0] eq;
        logic        ee;
        int          el, cyc;
        bit          seen;
        ref_div(n, d, eq, ee, el);
        @(negedge clk);
        start = 1'b1; n_in = n; d_in = d;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; seen = 0;
        while (cyc <= 20 && !seen) begin
            if (done) seen = 1;
            else begin
                chk({tag, "_busy"}, busy, 1);
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk({tag, "_seen"}, seen, 1);
        chk({tag, "_lat"}, cyc, el);
        chk({tag, "_q"}, q, eq);
        chk({tag, "_err"}, err, ee);
        chk({tag, "_busy_at_done"}, busy, 0);
        qo = q;
        @(posedge clk); #1;
        chk({tag, "_pulse"}, done, 0);
        chk({tag, "_q_hold"}, q, eq);
    endtask

    initial begin
        logic [15:0] qr, eq, n, d;
        logic        ee;
        int          el, dones, first_done, second_done;

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_q", q, 0);
        @(negedge clk); reset = 1'b0;

        run_op("t1", 16'h2000, 16'h3000, qr);
        chk("t1_tol", near(qr, 16'h2AAA, 2), 1);

        run_op("t2", 16'h4000, 16'h2000, qr);
        chk("t2_range", (qr >= 16'h7FFE && qr <= 16'h8000), 1);

        run_op("t3_zero", 16'h1234, 16'h0000, qr);
        run_op("t3_one", 16'h1234, 16'h4000, qr);

        run_op("t6_sat", 16'hFFFF, 16'h2000, qr);
        chk("t6_q", qr, 16'hFFFF);

        // start re-pulsed mid-iteration with different operands: ignored
        ref_div(16'h2000, 16'h3000, eq, ee, el);
        @(negedge clk); start = 1'b1; n_in = 16'h2000; d_in = 16'h3000;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; n_in = 16'h7000; d_in = 16'h0000;
        @(negedge clk); start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) begin
                dones++;
                chk("t4_q", q, eq);
                chk("t4_err", err, 0);
            end
        end
        chk("t4_dones", dones, 1);

        // start held high: re-accepted in the IDLE cycle after DONE
        @(negedge clk); start = 1'b1; n_in = 16'h2000; d_in = 16'h3000;
        first_done = -1; second_done = -1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (done && first_done < 0) first_done = i;
            else if (done && second_done < 0) second_done = i;
        end
        @(negedge clk); start = 1'b0;
        chk("held_first", first_done, ITERS + 1);
        chk("held_gap", second_done - first_done, ITERS + 2);
        repeat (8) @(posedge clk);

        // reset during ITER cycle 2
        @(negedge clk); start = 1'b1; n_in = 16'h3000; d_in = 16'h2800;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; #1;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_q", q, 0);
        chk("t5_err", err, 0);
        @(negedge clk); reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("t5_no_done", dones, 0);

        for (int i = 0; i < 30; i++) begin
            n = 16'($urandom);
            if ($urandom_range(0, 4) == 0) d = 16'($urandom);
            else d = {3'b001, 13'($urandom)};
            run_op($sformatf("rnd%0d", i), n, d, qr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
